// File: rtl/seg_share_ctrl_if.sv
// rtl/seg_share_ctrl_if.sv - request/value/grant bundle between display requesters and the share controller
// The controller side takes the slave modport; requesters drive through master.
interface seg_share_ctrl_if;
  logic [1:0]  req;
  logic [15:0] val0;
  logic [15:0] val1;
  logic [1:0]  gnt;

  modport master (output req, output val0, output val1, input gnt);
  modport slave  (input req, input val0, input val1, output gnt);
endinterface

// File: rtl/seg_share_ctrl.sv
// rtl/seg_share_ctrl.sv - round-robin share of a 4-digit seven-segment display between two requesters
// Values are snapshotted at frame start so a displayed frame never tears.
module seg_share_ctrl #(
  parameter int SCAN_DIV    = 65536,
  parameter int HOLD_FRAMES = 4
) (
  input  logic              clk,
  input  logic              clr,
  seg_share_ctrl_if.slave   bus,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              frame_end
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] HOLD_F   = FW'(HOLD_FRAMES);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_q, state_d;
  logic [1:0]    gnt_q, gnt_d;
  logic          last_q, last_d;
  logic [15:0]   snap_q, snap_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    digit_q, digit_d;
  logic [FW-1:0] frames_q, frames_d;

  logic          boundary;
  logic          cur, oth, winner;
  logic [FW-1:0] f_next;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      snap_q   <= 16'h0000;
      div_q    <= '0;
      digit_q  <= 2'd0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      snap_q   <= snap_d;
      div_q    <= div_d;
      digit_q  <= digit_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    snap_d   = snap_q;
    div_d    = div_q;
    digit_d  = digit_q;
    frames_d = frames_q;

    boundary = (state_q == SHOW) && (digit_q == 2'd3) && (div_q == DIV_LAST);
    cur      = gnt_q[1];
    oth      = ~gnt_q[1];
    f_next   = (frames_q >= HOLD_F) ? HOLD_F : frames_q + 1'b1;
    // Contention goes to whoever was not served last.
    winner   = (bus.req == 2'b11) ? ~last_q : bus.req[1];

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = SHOW;
          gnt_d    = winner ? 2'b10 : 2'b01;
          last_d   = winner;
          snap_d   = winner ? bus.val1 : bus.val0;
          div_d    = '0;
          digit_d  = 2'd0;
          frames_d = '0;
        end
      end
      SHOW: begin
        if (!boundary) begin
          if (div_q == DIV_LAST) begin
            div_d   = '0;
            digit_d = digit_q + 2'd1;
          end else begin
            div_d = div_q + 1'b1;
          end
        end else begin
          div_d   = '0;
          digit_d = 2'd0;
          if ((!bus.req[cur] && bus.req[oth]) ||
              (bus.req[cur] && bus.req[oth] && f_next == HOLD_F)) begin
            gnt_d    = oth ? 2'b10 : 2'b01;
            last_d   = oth;
            snap_d   = oth ? bus.val1 : bus.val0;
            frames_d = '0;
          end else if (!bus.req[cur]) begin
            state_d = IDLE;
            gnt_d   = 2'b00;
          end else begin
            snap_d   = cur ? bus.val1 : bus.val0;
            frames_d = f_next;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_comb begin
    an        = 4'b1111;
    seg       = 7'b1111111;
    frame_end = boundary;
    if (state_q == SHOW) begin
      an  = ~(4'b0001 << digit_q);
      seg = hex7(snap_q[{digit_q, 2'b00} +: 4]);
    end
  end

  assign bus.gnt = gnt_q;

endmodule

// File: tb/tb_seg_share_ctrl.sv
// tb/tb_seg_share_ctrl.sv - scoreboard bench for seg_share_ctrl with SCAN_DIV=4, HOLD_FRAMES=2
// Driver pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_seg_share_ctrl;
  localparam int SD = 4;
  localparam int HF = 2;
  localparam int FL = 4 * SD;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       frame_end;

  always #5 clk = ~clk;

  seg_share_ctrl_if bus ();

  seg_share_ctrl #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clk       (clk),
    .clr       (clr),
    .bus       (bus),
    .an        (an),
    .seg       (seg),
    .frame_end (frame_end)
  );

  typedef struct packed {
    logic [1:0] gnt;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fe;
  } exp_t;

  logic [6:0] HEX [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                           7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                           7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                           7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  bit          m_show;
  bit          m_idx;
  bit          m_last;
  logic [15:0] m_snap;
  int          m_pos;
  int          m_frames;

  function automatic void m_reset();
    m_show = 0; m_idx = 0; m_last = 1; m_snap = 16'h0; m_pos = 0; m_frames = 0;
  endfunction

  function automatic void m_take(input bit w, input bit is_new);
    m_idx = w;
    m_last = w;
    m_snap = w ? bus.val1 : bus.val0;
    if (is_new) m_frames = 0;
  endfunction

  function automatic void m_step();
    int f;
    bit g;
    bit o;
    if (clr) begin
      m_reset();
    end else if (!m_show) begin
      if (bus.req != 2'b00) begin
        m_show = 1;
        m_pos  = 0;
        m_take((bus.req == 2'b11) ? !m_last : bus.req[1], 1'b1);
      end
    end else if (m_pos == FL - 1) begin
      f = (m_frames + 1 > HF) ? HF : m_frames + 1;
      g = m_idx;
      o = !g;
      m_pos = 0;
      if (!bus.req[g] && bus.req[o])    m_take(o, 1'b1);
      else if (!bus.req[g])             m_show = 0;
      else if (bus.req[o] && f == HF)   m_take(o, 1'b1);
      else begin
        m_snap   = g ? bus.val1 : bus.val0;
        m_frames = f;
      end
    end else begin
      m_pos++;
    end
  endfunction

  function automatic exp_t m_out();
    exp_t e;
    int d;
    logic [15:0] s;
    e.gnt = 2'b00; e.an = 4'b1111; e.seg = 7'b1111111; e.fe = 1'b0;
    if (m_show) begin
      d = m_pos / SD;
      s = m_snap;
      e.gnt = m_idx ? 2'b10 : 2'b01;
      e.an  = ~(4'b0001 << d);
      e.seg = HEX[s[d*4 +: 4]];
      e.fe  = (m_pos == FL - 1);
    end
    return e;
  endfunction

  task automatic cyc(input logic c, input logic [1:0] r, input logic [15:0] v0,
                     input logic [15:0] v1, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      m_step();
      clr = c; bus.req = r; bus.val0 = v0; bus.val1 = v1;
      if (c) m_reset();
      sb.push_back(m_out());
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("gnt", int'(bus.gnt), int'(e.gnt));
      chk("an", int'(an), int'(e.an));
      chk("seg", int'(seg), int'(e.seg));
      chk("frame_end", int'(frame_end), int'(e.fe));
    end
  end

  initial begin
    clr = 1'b1; bus.req = 2'b00; bus.val0 = 16'h0; bus.val1 = 16'h0;
    m_reset();
    // reset, then idle
    cyc(1, 2'b00, 16'h0, 16'h0, 3);
    cyc(0, 2'b00, 16'h0, 16'h0, 100);
    // single requester, then asynchronous clear mid-frame
    cyc(0, 2'b01, 16'h12AF, 16'h0, 40);
    cyc(1, 2'b01, 16'h12AF, 16'h0, 2);
    // simultaneous first request from reset
    cyc(0, 2'b11, 16'h1234, 16'hABCD, 140);
    // mid-frame drop then re-request by requester 1
    cyc(1, 2'b00, 16'h0, 16'h0, 1);
    cyc(0, 2'b01, 16'h5678, 16'h0, FL + 6);
    cyc(0, 2'b00, 16'h5678, 16'h0, 20);
    cyc(0, 2'b10, 16'h0, 16'h9ABC, 10);
    cyc(0, 2'b00, 16'h0, 16'h9ABC, 20);
    // snapshot stability: value change during digit 2
    cyc(1, 2'b00, 16'h0, 16'h0, 1);
    cyc(0, 2'b01, 16'h0000, 16'h0, 1 + 2 * SD);
    cyc(0, 2'b01, 16'hFFFF, 16'h0, 30);
    // hold override after five frames
    cyc(1, 2'b00, 16'h0, 16'h0, 1);
    cyc(0, 2'b01, 16'h0F0F, 16'hC3C3, 1 + 5 * FL + 6);
    cyc(0, 2'b11, 16'h0F0F, 16'hC3C3, 40);
    cyc(0, 2'b00, 16'h0F0F, 16'hC3C3, 20);
    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
